// File: rtl/ring_sequence_checker.sv
// rtl/ring_sequence_checker.sv - run-time legality monitor for a one-hot ring-counter bus
//
// Samples a WIDTH-bit ring-counter bus and decodes it to a binary position. Each
// step is checked against the legal rotate sequence. The checker locks onto a
// clean sequence, flags and counts violations, and counts completed laps.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active-low
//   q_in_i       ring-counter bus under observation (WIDTH)
//   clear_err_i  clears err/err_cnt; also returns FAULT to HUNT
//   pos_o        binary index of the set bit of the last one-hot sample (PW)
//   pos_valid_o  last sample was one-hot
//   locked_o     checker is in LOCKED
//   err_o        sticky violation flag
//   err_cnt_o    violation count, saturating (ERR_W)
//   lap_pulse_o  one-cycle pulse per completed lap while locked
//   lap_cnt_o    lap count, wraps (LAP_W)
module ring_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int LAP_W    = 8,
  parameter int ERR_W    = 8,
  localparam int PW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] q_in_i,
  input  logic             clear_err_i,
  output logic [PW-1:0]    pos_o,
  output logic             pos_valid_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             lap_pulse_o,
  output logic [LAP_W-1:0] lap_cnt_o
);

  // Advance counter only needs to reach LOCK_CNT.
  localparam int AW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    adv_q, adv_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] prev_q;
  logic [PW-1:0]    pos_q;
  logic             pos_valid_q;
  logic             locked_q;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             lap_pulse_q;
  logic [LAP_W-1:0] lap_cnt_q;

  // Classification of the stage-1 sample against the last one-hot sample.
  logic             is_onehot;
  logic             is_hold;
  logic             is_adv;
  logic             is_restart;
  logic             is_violation;
  logic             is_wrap;
  logic [WIDTH-1:0] rot_prev;
  logic [PW-1:0]    idx;

  assign rot_prev  = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign is_onehot = (q_q != '0) && ((q_q & (q_q - WIDTH'(1))) == '0);
  assign is_hold   = is_onehot && (q_q == prev_q);
  assign is_adv    = is_onehot && (q_q == rot_prev);
  assign is_restart = is_onehot && (q_q == WIDTH'(1)) && !is_adv && !is_hold;
  // Anything not hold/advance/restart is a violation: either not one-hot or a skip.
  assign is_violation = !(is_hold || is_adv || is_restart);
  // A lap closes on the rotate from the top bit back to bit 0; a restart to
  // bit 0 from elsewhere is not an advance and so never matches.
  assign is_wrap = is_adv && prev_q[WIDTH-1] && q_q[0];

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_q[i]) idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    adv_d   = adv_q;
    case (state_q)
      ST_HUNT: begin
        if (is_onehot) begin
          state_d = ST_TRACK;
          adv_d   = '0;
        end
      end
      ST_TRACK: begin
        if (is_violation) begin
          state_d = ST_HUNT;
        end else if (is_adv) begin
          adv_d = adv_q + AW'(1);
          if (adv_q == AW'(LOCK_CNT - 1)) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (is_violation) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (clear_err_i) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Violations are only recorded once locked; clear always wins over a
  // same-cycle violation.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (clear_err_i) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (is_violation && (state_q == ST_LOCKED || state_q == ST_FAULT)) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q         <= '0;
      prev_q      <= '0;
      state_q     <= ST_HUNT;
      adv_q       <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      lap_pulse_q <= 1'b0;
      lap_cnt_q   <= '0;
    end else begin
      q_q         <= q_in_i;
      state_q     <= state_d;
      adv_q       <= adv_d;
      // locked follows the next state so it tracks the state transition edge.
      locked_q    <= (state_d == ST_LOCKED);
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      pos_valid_q <= is_onehot;
      if (is_onehot) begin
        prev_q <= q_q;
        pos_q  <= idx;
      end
      lap_pulse_q <= (state_q == ST_LOCKED) && is_wrap;
      if ((state_q == ST_LOCKED) && is_wrap) lap_cnt_q <= lap_cnt_q + LAP_W'(1);
    end
  end

  assign pos_o       = pos_q;
  assign pos_valid_o = pos_valid_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;
  assign lap_pulse_o = lap_pulse_q;
  assign lap_cnt_o   = lap_cnt_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb/tb_ring_sequence_checker.sv - scoreboard bench for ring_sequence_checker
module tb_ring_sequence_checker;

  localparam int X = -1;

  logic       clk_i;
  logic       rst_ni;
  logic [3:0] q_in_i;
  logic       clear_err_i;
  logic [1:0] pos_o;
  logic       pos_valid_o;
  logic       locked_o;
  logic       err_o;
  logic [7:0] err_cnt_o;
  logic       lap_pulse_o;
  logic [7:0] lap_cnt_o;

  ring_sequence_checker #(
    .WIDTH(4), .LOCK_CNT(2), .LAP_W(8), .ERR_W(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .q_in_i      (q_in_i),
    .clear_err_i (clear_err_i),
    .pos_o       (pos_o),
    .pos_valid_o (pos_valid_o),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .lap_pulse_o (lap_pulse_o),
    .lap_cnt_o   (lap_cnt_o)
  );

  typedef struct {
    string tag;
    int    due;
    int    pos;
    int    pv;
    int    lk;
    int    err;
    int    ecnt;
    int    lp;
    int    lcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   clr_pend = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic check_field(input string tag, input int act, input int exp);
    if (exp != X) check_eq(tag, act, exp);
  endtask

  // Compare every scoreboard entry whose output is now due.
  task automatic check_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_field({e.tag, ".pos"},       int'(pos_o),       e.pos);
      check_field({e.tag, ".pos_valid"}, int'(pos_valid_o), e.pv);
      check_field({e.tag, ".locked"},    int'(locked_o),    e.lk);
      check_field({e.tag, ".err"},       int'(err_o),       e.err);
      check_field({e.tag, ".err_cnt"},   int'(err_cnt_o),   e.ecnt);
      check_field({e.tag, ".lap_pulse"}, int'(lap_pulse_o), e.lp);
      check_field({e.tag, ".lap_cnt"},   int'(lap_cnt_o),   e.lcnt);
    end
  endtask

  // Drive one sample; clear is delayed one cycle so it lands on the edge that
  // classifies this sample. Expected outputs appear two edges later.
  task automatic step(input string tag, input logic [3:0] q, input bit clr,
                      input int pos, input int pv, input int lk, input int err,
                      input int ecnt, input int lp, input int lcnt);
    exp_t e;
    @(negedge clk_i);
    check_due();
    q_in_i      = q;
    clear_err_i = clr_pend;
    clr_pend    = clr;
    e.tag = tag; e.due = cyc + 2;
    e.pos = pos; e.pv = pv; e.lk = lk; e.err = err;
    e.ecnt = ecnt; e.lp = lp; e.lcnt = lcnt;
    sb.push_back(e);
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk_i);
      check_due();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".pos"},       int'(pos_o),       0);
    check_eq({tag, ".pos_valid"}, int'(pos_valid_o), 0);
    check_eq({tag, ".locked"},    int'(locked_o),    0);
    check_eq({tag, ".err"},       int'(err_o),       0);
    check_eq({tag, ".err_cnt"},   int'(err_cnt_o),   0);
    check_eq({tag, ".lap_pulse"}, int'(lap_pulse_o), 0);
    check_eq({tag, ".lap_cnt"},   int'(lap_cnt_o),   0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    q_in_i      = 4'b0100;
    clear_err_i = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk_i);
    rst_ni = 1'b1;

    //    tag          q        clr pos pv lk er ec lp lc
    step("t1_first",   4'b0100, 0,  2,  1, 0, 0, 0, 0, 0);

    step("t2_restart", 4'b0001, 0,  0,  1, 0, 0, 0, 0, 0);
    step("t2_adv1",    4'b0010, 0,  1,  1, 0, 0, 0, 0, 0);
    step("t2_lock",    4'b0100, 0,  2,  1, 1, 0, 0, 0, 0);
    step("t2_adv3",    4'b1000, 0,  3,  1, 1, 0, 0, 0, 0);
    step("t2_lap",     4'b0001, 0,  0,  1, 1, 0, 0, 1, 1);
    step("t2_nolap",   4'b0010, 0,  1,  1, 1, 0, 0, 0, 1);
    step("t2_at2",     4'b0100, 0,  2,  1, 1, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++)
      step("t3_hold",  4'b0100, 0,  2,  1, 1, 0, 0, 0, 1);
    step("t3_adv",     4'b1000, 0,  3,  1, 1, 0, 0, 0, 1);

    step("t4_lap",     4'b0001, 0,  0,  1, 1, 0, 0, 1, 2);
    step("t4_adv1",    4'b0010, 0,  1,  1, 1, 0, 0, 0, 2);
    step("t4_adv2",    4'b0100, 0,  2,  1, 1, 0, 0, 0, 2);
    step("t4_restart", 4'b0001, 0,  0,  1, 1, 0, 0, 0, 2);

    step("t5_illegal", 4'b0110, 0,  0,  0, 0, 1, 1, 0, 2);
    step("t5_fadv",    4'b0010, 0,  1,  1, 0, 1, 1, 0, 2);
    step("t5_skip",    4'b1000, 0,  3,  1, 0, 1, 2, 0, 2);
    step("t5_clear",   4'b0110, 1,  3,  0, 0, 0, 0, 0, 2);
    step("t5_hunt",    4'b0100, 0,  2,  1, 0, 0, 0, 0, 2);
    step("t5_trk_rst", 4'b0001, 0,  0,  1, 0, 0, 0, 0, 2);
    step("t5_trk_skp", 4'b1000, 0,  3,  1, 0, 0, 0, 0, 2);

    step("t6_enter",   4'b0001, 0,  0,  1, 0, 0, 0, 0, 2);
    step("t6_adv1",    4'b0010, 0,  1,  1, 0, 0, 0, 0, 2);
    step("t6_lock",    4'b0100, 0,  2,  1, 1, 0, 0, 0, 2);
    step("t6_adv3",    4'b1000, 0,  3,  1, 1, 0, 0, 0, 2);
    step("t6_lap3",    4'b0001, 0,  0,  1, 1, 0, 0, 1, 3);
    step("t6_hold",    4'b0001, 0,  0,  1, 1, 0, 0, 0, 3);
    drain();

    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("rst_mid");
    #1 rst_ni = 1'b1;

    step("t6_re_enter", 4'b0001, 0, 0,  1, 0, 0, 0, 0, 0);
    step("t6_re_adv1",  4'b0010, 0, 1,  1, 0, 0, 0, 0, 0);
    step("t6_re_lock",  4'b0100, 0, 2,  1, 1, 0, 0, 0, 0);
    drain();
    check_eq("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
